// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared ID/EX stage encodings, x0 constant and payload layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int RD_W_DEF = 5;
  localparam logic [RD_W_DEF-1:0] X0 = '0;

  // Field layout of the 160-bit decoded payload, shared by decode and execute.
  localparam int IDEX_FIELD_W  = 32;
  localparam int IDEX_PC_LSB   = 0;
  localparam int IDEX_PC4_LSB  = 32;
  localparam int IDEX_IMM_LSB  = 64;
  localparam int IDEX_OPND_LSB = 96;
  localparam int IDEX_CTRL_LSB = 128;
  localparam int IDEX_DATA_W   = 160;

  function automatic logic [IDEX_FIELD_W-1:0] idex_field(
    input logic [IDEX_DATA_W-1:0] payload,
    input int                     lsb
  );
    return payload[lsb +: IDEX_FIELD_W];
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/id_ex_entry.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_entry
// Description : One ID/EX holding slot: payload, rd, regwrite, valid and
//               source-register hit comparators.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              regwrite_i,
  input  logic [RD_W-1:0]   rs1_i,
  input  logic [RD_W-1:0]   rs2_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              regwrite_o,
  output logic              rs1_hit_o,
  output logic              rs2_hit_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              regwrite_q, regwrite_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    if (load_i) begin
      valid_d    = 1'b1;
      data_d     = data_i;
      rd_d       = rd_i;
      regwrite_d = regwrite_i;
    end else if (clear_i) begin
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is never cleared; the top masks it when the slot is empty.
  always_ff @(posedge clk) begin
    data_q     <= data_d;
    rd_q       <= rd_d;
    regwrite_q <= regwrite_d;
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign rd_o       = rd_q;
  assign regwrite_o = regwrite_q;

  assign rs1_hit_o = valid_q & regwrite_q & (rd_q == rs1_i) & (rs1_i != RD_W'(X0));
  assign rs2_hit_o = valid_q & regwrite_q & (rd_q == rs2_i) & (rs2_i != RD_W'(X0));

endmodule : id_ex_entry
`default_nettype wire

// File: rtl/id_ex_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_buf
// Description : Elastic ID/EX stage with flush and hazard hit reporting.
//               Define ID_EX_SKID_EN for the two-entry registered-ready build.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 160,
  parameter int RD_W        = RD_W_DEF,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              regwrite_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              regwrite_o,
  input  logic [RD_W-1:0]   rs1_i,
  input  logic [RD_W-1:0]   rs2_i,
  output logic              rs1_hit_o,
  output logic              rs2_hit_o,
  output logic [1:0]        count_o
);

  state_e state_q, state_d;

  logic in_fire, out_fire;
  logic head_load, head_clear;

  logic              head_valid;
  logic [DATA_W-1:0] head_data, head_data_in;
  logic [RD_W-1:0]   head_rd, head_rd_in;
  logic              head_rw, head_rw_in;
  logic              head_hit1, head_hit2;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

`ifdef ID_EX_SKID_EN
  logic              skid_load, skid_clear, head_from_skid;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [RD_W-1:0]   skid_rd;
  logic              skid_rw;
  logic              skid_hit1, skid_hit2;

  assign head_data_in = head_from_skid ? skid_data : data_i;
  assign head_rd_in   = head_from_skid ? skid_rd   : rd_i;
  assign head_rw_in   = head_from_skid ? skid_rw   : regwrite_i;

  // Registered ready: decode never sees execute's stall combinationally.
  assign ready_o = (state_q != ST_FULL);
`else
  assign head_data_in = data_i;
  assign head_rd_in   = rd_i;
  assign head_rw_in   = regwrite_i;

  assign ready_o = ~valid_o | ready_i;
`endif

  always_comb begin
    state_d    = state_q;
    head_load  = 1'b0;
    head_clear = 1'b0;
`ifdef ID_EX_SKID_EN
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    head_from_skid = 1'b0;
`endif
    if (flush_i) begin
      state_d    = ST_EMPTY;
      head_clear = 1'b1;
`ifdef ID_EX_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_load = 1'b1;
`ifdef ID_EX_SKID_EN
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
`endif
          end else if (out_fire) begin
            head_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
`ifdef ID_EX_SKID_EN
        ST_FULL: begin
          if (out_fire) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ST_ONE;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  id_ex_entry #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_head (
    .clk        (clk),
    .rst        (rst),
    .load_i     (head_load),
    .clear_i    (head_clear),
    .data_i     (head_data_in),
    .rd_i       (head_rd_in),
    .regwrite_i (head_rw_in),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .valid_o    (head_valid),
    .data_o     (head_data),
    .rd_o       (head_rd),
    .regwrite_o (head_rw),
    .rs1_hit_o  (head_hit1),
    .rs2_hit_o  (head_hit2)
  );

`ifdef ID_EX_SKID_EN
  id_ex_entry #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load_i     (skid_load),
    .clear_i    (skid_clear),
    .data_i     (data_i),
    .rd_i       (rd_i),
    .regwrite_i (regwrite_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .valid_o    (skid_valid),
    .data_o     (skid_data),
    .rd_o       (skid_rd),
    .regwrite_o (skid_rw),
    .rs1_hit_o  (skid_hit1),
    .rs2_hit_o  (skid_hit2)
  );

  // skid_valid mirrors ST_FULL; it only gates the skid comparators.
  assign rs1_hit_o = head_hit1 | (skid_valid & skid_hit1);
  assign rs2_hit_o = head_hit2 | (skid_valid & skid_hit2);
`else
  assign rs1_hit_o = head_hit1;
  assign rs2_hit_o = head_hit2;
`endif

  assign valid_o = head_valid;

  generate
    if (ZERO_BUBBLE) begin : g_zero_bubble
      assign data_o     = head_valid ? head_data : '0;
      assign rd_o       = head_valid ? head_rd   : '0;
      assign regwrite_o = head_valid & head_rw;
    end else begin : g_raw_bubble
      assign data_o     = head_data;
      assign rd_o       = head_rd;
      assign regwrite_o = head_rw;
    end
  endgenerate

  always_comb begin
    count_o = 2'd0;
    case (state_q)
      ST_ONE:  count_o = 2'd1;
      ST_FULL: count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

endmodule : id_ex_stage_buf
`default_nettype wire

// File: tb/tb_id_ex_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage_buf
// Description : Self-checking bench for id_ex_stage_buf against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_buf;

  localparam int DW = 160;
  localparam int RW = 5;
`ifdef ID_EX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, flush_i, valid_i, ready_i, regwrite_i;
  logic [DW-1:0] data_i;
  logic [RW-1:0] rd_i, rs1_i, rs2_i;
  logic          ready_o, valid_o, regwrite_o, rs1_hit_o, rs2_hit_o;
  logic [DW-1:0] data_o;
  logic [RW-1:0] rd_o;
  logic [1:0]    count_o;

  always #5 clk = ~clk;

  id_ex_stage_buf #(.DATA_W(DW), .RD_W(RW), .ZERO_BUBBLE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_i     (data_i),
    .rd_i       (rd_i),
    .regwrite_i (regwrite_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .rd_o       (rd_o),
    .regwrite_o (regwrite_o),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rs1_hit_o  (rs1_hit_o),
    .rs2_hit_o  (rs2_hit_o),
    .count_o    (count_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [RW-1:0] rd;
    logic          rw;
  } ent_t;

  ent_t mq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   last_in_fire;

  // Reference model: a FIFO of capacity CAP.
  function automatic bit m_ready();
    if (CAP == 2) return mq.size() < 2;
    return (mq.size() == 0) || ready_i;
  endfunction

  function automatic bit m_hit(input logic [RW-1:0] rs);
    foreach (mq[i]) if (mq[i].rw && mq[i].rd == rs && rs != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [171:0] m_expect();
    ent_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    return {mq.size() > 0, m_ready(), 2'(mq.size()), h.d, h.rd, h.rw, m_hit(rs1_i), m_hit(rs2_i)};
  endfunction

  task automatic tick();
    bit   inf, outf;
    ent_t e;
    inf  = valid_i && m_ready();
    outf = (mq.size() > 0) && ready_i;
    e.d  = data_i;
    e.rd = rd_i;
    e.rw = regwrite_i;
    last_in_fire = inf && !rst && !flush_i;
    @(posedge clk);
    if (rst || flush_i) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf)  mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush_i = 0; valid_i = 0; ready_i = 0; regwrite_i = 0;
    data_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    @(negedge clk);
    tick(); tick();
    rst = 0;
    rs1_i = 5'd3; rs2_i = 5'd7;
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
    n_checks++; if (count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    n_checks++; if ({rs1_hit_o, rs2_hit_o} !== 2'b00) begin n_fail++; $display("FAIL reset_hits got=%b exp=00", {rs1_hit_o, rs2_hit_o}); end
    n_checks++; if ({data_o, rd_o, regwrite_o} !== '0) begin n_fail++; $display("FAIL reset_zero_bubble got=%h exp=0", {data_o, rd_o, regwrite_o}); end
  endtask

  task automatic test_stream();
    ready_i = 1; valid_i = 1; regwrite_i = 1; rd_i = 5'd1;
    for (int i = 1; i <= 8; i++) begin
      data_i = DW'(i);
      #1;
      if (i > 1) begin
        n_checks++; if (data_o !== DW'(i - 1) || valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_data[%0d] got=%h/%0b exp=%h/1", i, data_o, valid_o, DW'(i - 1)); end
        n_checks++; if (count_o !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count_o); end
      end
      tick();
    end
    valid_i = 0;
    #1;
    n_checks++; if (data_o !== DW'(8)) begin n_fail++; $display("FAIL stream_last got=%h exp=8", data_o); end
    tick();
    #1;
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_drained got=%0b exp=0", valid_o); end
  endtask

`ifdef ID_EX_SKID_EN
  task automatic test_skid_stall();
    logic [DW-1:0] seq [3];
    seq[0] = DW'(8'h11); seq[1] = DW'(8'h22); seq[2] = DW'(8'h33);
    ready_i = 0; valid_i = 1;
    data_i = seq[0]; tick();
    data_i = seq[1]; #1;
    n_checks++; if (count_o !== 2'd1 || ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_c1 got=%0d/%0b exp=1/1", count_o, ready_o); end
    tick();
    data_i = seq[2]; #1;
    n_checks++; if (count_o !== 2'd2 || ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_c2 got=%0d/%0b exp=2/0", count_o, ready_o); end
    tick();
    ready_i = 1; #1;
    n_checks++; if (valid_o !== 1'b1 || data_o !== seq[0] || ready_o !== 1'b0) begin n_fail++; $display("FAIL drain0 got=%h/%0b exp=%h/0", data_o, ready_o, seq[0]); end
    tick(); #1;
    n_checks++; if (data_o !== seq[1] || ready_o !== 1'b1) begin n_fail++; $display("FAIL drain1 got=%h/%0b exp=%h/1", data_o, ready_o, seq[1]); end
    tick();
    valid_i = 0; #1;
    n_checks++; if (data_o !== seq[2] || count_o !== 2'd1) begin n_fail++; $display("FAIL drain2 got=%h/%0d exp=%h/1", data_o, count_o, seq[2]); end
    tick(); #1;
    n_checks++; if (valid_o !== 1'b0 || count_o !== 2'd0) begin n_fail++; $display("FAIL drain_empty got=%0b/%0d exp=0/0", valid_o, count_o); end
  endtask
`else
  task automatic test_nonskid_toggle();
    int sent = 0, recv = 0;
    valid_i = 1; regwrite_i = 0; data_i = DW'(100);
    for (int c = 0; c < 16; c++) begin
      ready_i = c[0];
      #1;
      n_checks++; if (ready_o !== m_ready()) begin n_fail++; $display("FAIL toggle_ready[%0d] got=%0b exp=%0b", c, ready_o, m_ready()); end
      if (valid_o && ready_i) begin
        n_checks++; if (data_o !== DW'(100 + recv)) begin n_fail++; $display("FAIL toggle_order[%0d] got=%h exp=%h", c, data_o, DW'(100 + recv)); end
        recv++;
      end
      tick();
      if (last_in_fire) begin sent++; data_i = DW'(100 + sent); end
    end
    valid_i = 0; ready_i = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (valid_o) recv++;
      tick();
    end
    n_checks++; if (recv !== sent || sent < 4) begin n_fail++; $display("FAIL toggle_count got=%0d exp=%0d", recv, sent); end
  endtask
`endif

  task automatic test_flush_full();
    ready_i = 0; valid_i = 1;
    for (int k = 0; k < CAP; k++) begin data_i = DW'(k + 1); tick(); end
    #1;
    n_checks++; if (count_o !== 2'(CAP)) begin n_fail++; $display("FAIL flush_fill got=%0d exp=%0d", count_o, CAP); end
    flush_i = 1; data_i = DW'(8'hAA);
    tick();
    flush_i = 0; valid_i = 0; #1;
    n_checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || count_o !== 2'd0) begin n_fail++; $display("FAIL flush_state got=%0b/%0b/%0d exp=0/1/0", valid_o, ready_o, count_o); end
    ready_i = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (valid_o !== 1'b0 || data_o === DW'(8'hAA)) begin n_fail++; $display("FAIL flush_leak[%0d] got=%0b/%h exp=0", c, valid_o, data_o); end
      tick();
    end
  endtask

  task automatic test_hits();
    ready_i = 0; valid_i = 1; rd_i = 5'd5; regwrite_i = 1; data_i = DW'(8'h55);
    rs1_i = 5'd5; rs2_i = 5'd3; #1;
    n_checks++; if (rs1_hit_o !== 1'b0) begin n_fail++; $display("FAIL hit_no_valid_i got=%0b exp=0", rs1_hit_o); end
    tick();
    valid_i = 0; #1;
    n_checks++; if (rs1_hit_o !== 1'b1 || rs2_hit_o !== 1'b0) begin n_fail++; $display("FAIL hit_rd5 got=%0b%0b exp=10", rs1_hit_o, rs2_hit_o); end
    flush_i = 1; tick(); flush_i = 0;
    valid_i = 1; regwrite_i = 0; tick(); valid_i = 0;
    rs2_i = 5'd5; #1;
    n_checks++; if (rs2_hit_o !== 1'b0) begin n_fail++; $display("FAIL hit_norw got=%0b exp=0", rs2_hit_o); end
    flush_i = 1; tick(); flush_i = 0;
    valid_i = 1; regwrite_i = 1; rd_i = 5'd0; tick(); valid_i = 0;
    rs1_i = 5'd0; #1;
    n_checks++; if (rs1_hit_o !== 1'b0) begin n_fail++; $display("FAIL hit_x0 got=%0b exp=0", rs1_hit_o); end
    flush_i = 1; tick(); flush_i = 0;
  endtask

  task automatic test_reset_full();
    ready_i = 0; valid_i = 1; regwrite_i = 1; rd_i = 5'd9;
    for (int k = 0; k < CAP; k++) begin data_i = DW'(k + 16); tick(); end
    rst = 1; data_i = DW'(8'h77); tick();
    rst = 0; valid_i = 0; rs1_i = 5'd9; rs2_i = 5'd9; #1;
    n_checks++; if ({valid_o, ready_o, count_o, rs1_hit_o, rs2_hit_o} !== 6'b010000) begin n_fail++; $display("FAIL rst_full_ctrl got=%b exp=010000", {valid_o, ready_o, count_o, rs1_hit_o, rs2_hit_o}); end
    n_checks++; if ({data_o, rd_o, regwrite_o} !== '0) begin n_fail++; $display("FAIL rst_full_zero got=%h exp=0", {data_o, rd_o, regwrite_o}); end
  endtask

  task automatic test_random();
    bit            pend = 0;
    logic [171:0]  exp_v, got_v;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        valid_i    = ($urandom_range(0, 3) != 0);
        data_i     = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rd_i       = RW'($urandom_range(0, 7));
        regwrite_i = 1'($urandom);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 19) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      rs1_i   = RW'($urandom_range(0, 7));
      rs2_i   = RW'($urandom_range(0, 7));
      #1;
      exp_v = m_expect();
      got_v = {valid_o, ready_o, count_o, data_o, rd_o, regwrite_o, rs1_hit_o, rs2_hit_o};
      n_checks++;
      if (got_v !== exp_v) begin n_fail++; $display("FAIL random[%0d] got=%h exp=%h", c, got_v, exp_v); end
      tick();
      pend = valid_i && !last_in_fire && !flush_i && !rst;
    end
    rst = 0; flush_i = 0; valid_i = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
`ifdef ID_EX_SKID_EN
    test_skid_stall();
`else
    test_nonskid_toggle();
`endif
    test_flush_full();
    test_hits();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_id_ex_stage_buf
`default_nettype wire

// File: doc/id_ex_stage_buf.md
# id_ex_stage_buf

Parametrised, elastic decode-to-execute pipeline stage that replaces the fixed ID/EX register. It carries an opaque decoded-instruction payload plus destination-register metadata under a valid/ready handshake and supports flush. It provides an optional two-entry skid buffer so that upstream `ready` is a registered signal, and reports destination-register hits for the hazard unit. It sits between the decode cycle and the execute cycle.

## Interface

Parameters:
- `DATA_W`, 160: payload width (PC, PC+4, immediate, operands, control bits packed by decode).
- `RD_W`, 5: register-address width.
- `ZERO_BUBBLE`, 1: when 1, `data_o`, `rd_o` and `regwrite_o` read zero whenever `valid_o`=0.

Ports: one clock; reset is synchronous and active-high.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous active-high reset.
- `flush_i` input 1: squash all held entries (branch mispredict or jump).
- `valid_i` input 1: decode presents an instruction.
- `ready_o` output 1: stage accepts this cycle.
- `data_i` input DATA_W: payload.
- `rd_i` input RD_W: destination register.
- `regwrite_i` input 1: instruction writes `rd_i`.
- `valid_o` output 1: head entry valid toward execute.
- `ready_i` input 1: execute consumes the head.
- `data_o` output DATA_W, `rd_o` output RD_W, `regwrite_o` output 1: head entry fields.
- `rs1_i`, `rs2_i` input RD_W: source registers of the instruction in decode.
- `rs1_hit_o`, `rs2_hit_o` output 1: the source matches a held, valid, writing entry.
- `count_o` output 2: occupancy (0 to 2).

## Operation

- `in_fire` = `valid_i & ready_o`. `out_fire` = `valid_o & ready_i`.
- States: EMPTY, ONE (head only), FULL (head and skid; skid build only).
- EMPTY: `in_fire` moves the entry to head and the state to ONE.
- ONE:
  - `in_fire` & `out_fire`: the head is replaced; the state stays ONE.
  - `in_fire` only: the entry goes to skid; the state goes to FULL.
  - `out_fire` only: the state goes to EMPTY.
- FULL:
  - `out_fire`: skid moves to head; the state goes to ONE.
  - `in_fire` is impossible because `ready_o`=0.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- `ready_o` = (state != FULL). It is a pure function of registered state.
- Flush: `flush_i`=1 at an edge sends the state to EMPTY. Any `in_fire` in the same cycle is discarded. `out_fire` in the same cycle still counts for the consumer.
- Reset has the same effect as flush. Reset has priority over everything; flush has priority over handshakes.
- Hit outputs:
  - `rsX_hit_o` = OR over valid entries of (`regwrite` & `rd`==`rsX_i` & `rsX_i`!=0).
  - They are combinational from state and `rsX_i`, with no dependence on `valid_i`.
- `count_o` = 0 in EMPTY, 1 in ONE, 2 in FULL.
- Payload registers load only on fire. They are not cleared on flush; `ZERO_BUBBLE` masks them at the outputs.

## Timing

- Latency from `in_fire` into EMPTY to `valid_o`=1 is 1 cycle.
- Throughput is 1 instruction per cycle while `ready_i`=1.
- Reset values: `valid_o`=0, `ready_o`=1, `count_o`=0, `rs1_hit_o`=`rs2_hit_o`=0.
- With `ZERO_BUBBLE`=1, `data_o`, `rd_o` and `regwrite_o` are also 0 at reset.
- After a flush edge, `valid_o`=0 and `ready_o`=1 in the next cycle.
- Upstream must hold `valid_i` and the payload stable until `in_fire`. The block does not check this.

## Configuration

- `ID_EX_SKID_EN` defined:
  - Two entries; FSM EMPTY/ONE/FULL as above.
  - `ready_o` is registered, which breaks the combinational path from execute stall to decode.
- `ID_EX_SKID_EN` undefined:
  - Single head entry; states EMPTY/ONE; `count_o` never exceeds 1.
  - `ready_o` = `~valid_o | ready_i` (combinational).
  - ONE with `in_fire` & `~out_fire` cannot occur.
- Flush, reset, hit logic and `ZERO_BUBBLE` behave the same in both builds.

## Structure

- Shared package `pipe_pkg` holds:
  - The state encoding (`ST_EMPTY`=2'd0, `ST_ONE`=2'd1, `ST_FULL`=2'd2).
  - `RD_W` default and the `x0` constant.
  - The ID/EX payload field offsets used by decode and execute to pack and unpack `data_i`.
- One sub-module, `id_ex_entry`: a single payload/rd/regwrite/valid holding register with load enable and per-entry hit comparator. It is instantiated once or twice.

## Test plan

- Reset, then stream `0x1`..`0x8` with `ready_i`=1:
  - `data_o` shows `0x1`..`0x8` on consecutive cycles, each 1 cycle after input.
  - `count_o` stays 1.
- Skid build, `ready_i`=0 for 3 cycles while `valid_i`=1:
  - `count_o` goes 1 then 2.
  - `ready_o`=0 from the 2nd cycle.
  - On release, the two held entries drain in order with no loss.
- FULL plus `flush_i` while `valid_i`=1 with `data_i`=`0xAA`:
  - The next cycle has `valid_o`=0, `ready_o`=1, `count_o`=0.
  - `0xAA` never appears.
- Held entry `rd`=5, `regwrite`=1:
  - `rs1_i`=5 gives `rs1_hit_o`=1.
  - `rs2_i`=5 with `regwrite`=0 gives 0.
  - `rs1_i`=0 with `rd`=0 gives 0.
- `rst` asserted mid-stream in FULL: all outputs return to reset values the next cycle, and `ZERO_BUBBLE` outputs read 0.
- Non-skid build, `ready_i` toggling every cycle: `ready_o` tracks `~valid_o | ready_i` combinationally, and no beat is lost.
